emulador_ov7670: RTL and testbench
==================================

# emulador_ov7670

Synthetic OV7670 pixel-bus transmitter: drives VSYNC, HREF, PCLK and an 8-bit D bus with OV7670-style frame timing and a deterministic RGB565 pattern. Serves as the far end of the camera capture path for simulation and FPGA loopback, so capture, quadrant sampling and storage can be exercised without a sensor. One frame is emitted per `iniciar` request.

## Interface
- `LINES`, 140, active lines per frame
- `COLUMNS`, 320, pixels per line (2 bytes each)
- `PCLK_DIV`, 2, system clocks per PCLK half-period (≥1)
- `VSYNC_TP`, 6, VSYNC high duration, in PCLK periods
- `V_BACK_TP`, 10, gap from VSYNC fall to first HREF rise, in PCLK periods
- `H_BLANK_TP`, 16, HREF low time after each line, in PCLK periods
- `clock`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `iniciar`  in  1  request one frame; sampled only in IDLE
- `modo`  in  1  0 = coordinate pattern, 1 = constant colour
- `cor`  in  16  RGB565 constant colour for `modo`=1, latched at frame start
- `VSYNC`  out  1  frame sync, active high
- `HREF`  out  1  line valid, active high
- `PCLK`  out  1  pixel clock, free-running after reset
- `D`  out  8  pixel byte, high byte first
- `ocupado`  out  1  high from accepted `iniciar` until `fim_frame`
- `fim_frame`  out  1  one-clock pulse at end of frame

## Operation
- PCLK: low for `PCLK_DIV` clocks, high for `PCLK_DIV` clocks, repeating. "Fall tick" = clock on which PCLK goes low; all of VSYNC/HREF/D/state change only on fall ticks, so D is stable at every PCLK rise.
- States: IDLE → VS (VSYNC_TP periods, VSYNC=1) → VBACK (V_BACK_TP) → ATIVA (2·COLUMNS periods, HREF=1) → HBLANK (H_BLANK_TP) → ATIVA for the next line, or DONE after line LINES-1 → IDLE.
- `iniciar`=1 in IDLE: `ocupado`=1 next clock; `modo`/`cor` latched; VS entered on the next fall tick.
- Byte toggle in ATIVA: even byte = pixel[15:8], odd = pixel[7:0]; column increments after odd byte; line increments at HBLANK entry.
- Pattern `modo`=0: pixel = {line[6:0], column[8:0]}. `modo`=1: pixel = latched `cor`.
- D = 8'h00 whenever HREF = 0.
- DONE: `fim_frame`=1 for one clock, `ocupado`=0 same clock, then IDLE.
- `iniciar` while `ocupado`=1, including the `fim_frame` clock, is ignored (not queued).
- Counter widths: line ⌈log2 LINES⌉, column ⌈log2 COLUMNS⌉, period counter sized to the largest of VSYNC_TP, V_BACK_TP, H_BLANK_TP, 2·COLUMNS.

## Timing
- Reset (asserted, async): VSYNC=HREF=PCLK=0, D=0, `ocupado`=0, `fim_frame`=0, state IDLE, all counters 0, PCLK divider restarts.
- Reset mid-frame: outputs return to reset values immediately; no `fim_frame`; a new frame requires a new `iniciar` after release.
- Latency `iniciar` → VSYNC rise: ≤ 2·PCLK_DIV+1 clocks.
- Frame length (VSYNC rise to `fim_frame`): (VSYNC_TP + V_BACK_TP + LINES·(2·COLUMNS + H_BLANK_TP))·2·PCLK_DIV clocks, ±1 clock.
- HREF rises/falls exactly on fall ticks; first D byte is valid at the first PCLK rise with HREF=1.

## Structure
- Shared package/header: state encoding (IDLE, VS, VBACK, ATIVA, HBLANK, DONE) and default timing constants, so capture-side benches use the same frame geometry.
- One sub-module: `divisor_pclk` (PCLK generation plus one-clock fall-tick strobe, parameter PCLK_DIV).
- Top holds FSM, period/byte/column/line counters, pattern mux.

## Test plan
- Reset: hold `reset`=0 → all outputs 0; release → PCLK toggles with period 2·PCLK_DIV, VSYNC/HREF stay 0, `ocupado`=0.
- LINES=3, COLUMNS=4, PCLK_DIV=2, `modo`=0, pulse `iniciar` → exactly 1 VSYNC pulse of 6 periods, 3 HREF pulses of 8 periods, line 1 col 2 bytes 0x02,0x02; line 2 col 3 bytes 0x04,0x03; one `fim_frame`; total clocks per formula.
- `modo`=1, `cor`=16'hF800 → every active byte pair is 0xF8,0x00; changing `cor` mid-frame has no effect.
- `iniciar` held high through a frame, incl. the `fim_frame` clock → exactly one frame emitted; next frame only after re-assertion in IDLE.
- Assert `reset` during line 1 of ATIVA → same-clock outputs to 0, no `fim_frame`; restart produces a complete, correct frame.
- Loopback into the capture path at default parameters → the nine stored quadrant samples equal {line[6:0], column[8:0]} at the sampled coordinates.

Source files
------------

// File: rtl/emulador_ov7670_pkg.sv
// Shared frame geometry and state encoding for the OV7670 bus emulator and
// the capture-side benches that talk to it.
package emulador_ov7670_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] VS     = 3'd1;
   localparam logic [2:0] VBACK  = 3'd2;
   localparam logic [2:0] ATIVA  = 3'd3;
   localparam logic [2:0] HBLANK = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam int unsigned DEF_LINES      = 140;
   localparam int unsigned DEF_COLUMNS    = 320;
   localparam int unsigned DEF_PCLK_DIV   = 2;
   localparam int unsigned DEF_VSYNC_TP   = 6;
   localparam int unsigned DEF_V_BACK_TP  = 10;
   localparam int unsigned DEF_H_BLANK_TP = 16;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned largura(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned maior4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/emulador_ov7670_divisor_pclk.sv
// Free-running PCLK generator: PCLK_DIV clocks low, PCLK_DIV clocks high,
// plus a strobe on the clock whose edge drives PCLK low.
module divisor_pclk
   import emulador_ov7670_pkg::*;
#(
   parameter int unsigned PCLK_DIV = DEF_PCLK_DIV
) (
   input  logic clock,
   input  logic reset,
   output logic pclk,
   output logic tick_desc
);

   localparam int unsigned CW = largura(PCLK_DIV);

   logic [CW-1:0] cnt;
   logic          fim_meio;

   assign fim_meio  = (cnt == CW'(PCLK_DIV - 1));
   // Strobe is high in the cycle before the falling edge so that state updated
   // by it changes together with PCLK going low.
   assign tick_desc = fim_meio & pclk;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         pclk <= 1'b0;
      end else if (fim_meio) begin
         cnt  <= '0;
         pclk <= ~pclk;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/emulador_ov7670.sv
// Synthetic OV7670 pixel-bus transmitter: one VSYNC/HREF frame of RGB565
// pixels (coordinate pattern or constant colour) per iniciar request.
module emulador_ov7670
   import emulador_ov7670_pkg::*;
#(
   parameter int unsigned LINES      = DEF_LINES,
   parameter int unsigned COLUMNS    = DEF_COLUMNS,
   parameter int unsigned PCLK_DIV   = DEF_PCLK_DIV,
   parameter int unsigned VSYNC_TP   = DEF_VSYNC_TP,
   parameter int unsigned V_BACK_TP  = DEF_V_BACK_TP,
   parameter int unsigned H_BLANK_TP = DEF_H_BLANK_TP
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic        modo,
   input  logic [15:0] cor,
   output logic        VSYNC,
   output logic        HREF,
   output logic        PCLK,
   output logic [7:0]  D,
   output logic        ocupado,
   output logic        fim_frame
);

   localparam int unsigned LW      = largura(LINES);
   localparam int unsigned CW      = largura(COLUMNS);
   localparam int unsigned PER_MAX = maior4(VSYNC_TP, V_BACK_TP, H_BLANK_TP, 2 * COLUMNS);
   localparam int unsigned PW      = largura(PER_MAX);

   logic [2:0]    estado;
   logic [PW-1:0] per_cnt;
   logic [PW-1:0] dur;
   logic          fim_per;
   logic          byte_sel;
   logic [CW-1:0] coluna;
   logic [LW-1:0] linha;
   logic          ultima;
   logic          modo_q;
   logic [15:0]   cor_q;
   logic          iniciar_q;
   logic          tick;
   logic [6:0]    lin7;
   logic [8:0]    col9;
   logic [15:0]   pixel;

   divisor_pclk #(.PCLK_DIV(PCLK_DIV)) u_divisor_pclk (
      .clock     (clock),
      .reset     (reset),
      .pclk      (PCLK),
      .tick_desc (tick)
   );

   always_comb begin
      dur = '0;
      case (estado)
         VS:      dur = PW'(VSYNC_TP - 1);
         VBACK:   dur = PW'(V_BACK_TP - 1);
         ATIVA:   dur = PW'(2 * COLUMNS - 1);
         HBLANK:  dur = PW'(H_BLANK_TP - 1);
         default: dur = '0;
      endcase
   end

   assign fim_per = (per_cnt == dur);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= IDLE;
         per_cnt   <= '0;
         byte_sel  <= 1'b0;
         coluna    <= '0;
         linha     <= '0;
         ultima    <= 1'b0;
         modo_q    <= 1'b0;
         cor_q     <= '0;
         iniciar_q <= 1'b0;
         VSYNC     <= 1'b0;
         HREF      <= 1'b0;
         ocupado   <= 1'b0;
         fim_frame <= 1'b0;
      end else begin
         iniciar_q <= iniciar;
         case (estado)
            IDLE: begin
               // A rising iniciar is required, so a level held across the
               // previous frame does not start a second one.
               if (!ocupado) begin
                  if (iniciar && !iniciar_q) begin
                     ocupado <= 1'b1;
                     modo_q  <= modo;
                     cor_q   <= cor;
                  end
               end else if (tick) begin
                  estado  <= VS;
                  VSYNC   <= 1'b1;
                  per_cnt <= '0;
               end
            end
            DONE: begin
               fim_frame <= 1'b0;
               estado    <= IDLE;
            end
            default: begin
               if (tick) begin
                  per_cnt <= fim_per ? '0 : per_cnt + 1'b1;
                  case (estado)
                     VS: begin
                        if (fim_per) begin
                           VSYNC  <= 1'b0;
                           estado <= VBACK;
                        end
                     end
                     VBACK: begin
                        if (fim_per) begin
                           estado <= ATIVA;
                           HREF   <= 1'b1;
                        end
                     end
                     ATIVA: begin
                        if (fim_per) begin
                           estado   <= HBLANK;
                           HREF     <= 1'b0;
                           ultima   <= (linha == LW'(LINES - 1));
                           linha    <= linha + 1'b1;
                           coluna   <= '0;
                           byte_sel <= 1'b0;
                        end else begin
                           byte_sel <= ~byte_sel;
                           if (byte_sel) coluna <= coluna + 1'b1;
                        end
                     end
                     HBLANK: begin
                        if (fim_per) begin
                           if (ultima) begin
                              estado    <= DONE;
                              fim_frame <= 1'b1;
                              ocupado   <= 1'b0;
                              linha     <= '0;
                              ultima    <= 1'b0;
                           end else begin
                              estado <= ATIVA;
                              HREF   <= 1'b1;
                           end
                        end
                     end
                     default: estado <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   // D only depends on registers that move on fall ticks, so it is stable at PCLK rise.
   always_comb begin
      lin7  = 7'(linha);
      col9  = 9'(coluna);
      pixel = modo_q ? cor_q : {lin7, col9};
      D     = 8'h00;
      if (HREF) D = byte_sel ? pixel[7:0] : pixel[15:8];
   end

endmodule

// File: tb/tb_emulador_ov7670.sv
// Directed/randomized bench for emulador_ov7670 against a frame-level byte model.
module tb_emulador_ov7670;

   localparam int unsigned L   = 3;
   localparam int unsigned C   = 4;
   localparam int unsigned PD  = 2;
   localparam int unsigned VTP = 6;
   localparam int unsigned VBP = 10;
   localparam int unsigned HBP = 16;
   localparam int unsigned FRAME_CLK = (VTP + VBP + L * (2 * C + HBP)) * 2 * PD;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        iniciar = 1'b0;
   logic        modo = 1'b0;
   logic [15:0] cor = '0;
   logic        VSYNC, HREF, PCLK, ocupado, fim_frame;
   logic [7:0]  D;

   emulador_ov7670 #(
      .LINES(L), .COLUMNS(C), .PCLK_DIV(PD),
      .VSYNC_TP(VTP), .V_BACK_TP(VBP), .H_BLANK_TP(HBP)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .cor(cor),
      .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK), .D(D),
      .ocupado(ocupado), .fim_frame(fim_frame)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [7:0]  cap[$];
   logic [7:0]  exp_q[$];
   int unsigned hlen[$];
   int unsigned vlen[$];
   int unsigned cur_h = 0, cur_v = 0, fim_cnt = 0, vs_rises = 0, pclk_rises = 0;
   int unsigned vs_cyc = 0, fim_cyc = 0;
   logic pclk_p = 1'b0, vs_p = 1'b0, ocup_fim = 1'b0;

   // Bus observer: bytes and pulse widths at PCLK rises, events per clock.
   always @(posedge clock) begin
      #1;
      if (PCLK && !pclk_p) begin
         pclk_rises++;
         if (HREF) begin
            cap.push_back(D);
            cur_h++;
         end else if (cur_h != 0) begin
            hlen.push_back(cur_h);
            cur_h = 0;
         end
         if (VSYNC) cur_v++;
         else if (cur_v != 0) begin
            vlen.push_back(cur_v);
            cur_v = 0;
         end
      end
      if (VSYNC && !vs_p) begin
         vs_rises++;
         vs_cyc = cyc;
      end
      if (fim_frame) begin
         fim_cnt++;
         fim_cyc  = cyc;
         ocup_fim = ocupado;
      end
      pclk_p = PCLK;
      vs_p   = VSYNC;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_mon();
      cap.delete(); hlen.delete(); vlen.delete();
      cur_h = 0; cur_v = 0; fim_cnt = 0; vs_rises = 0; pclk_rises = 0;
   endtask

   task automatic build_exp(input logic m, input logic [15:0] c);
      int unsigned pix;
      exp_q.delete();
      for (int unsigned l = 0; l < L; l++)
         for (int unsigned k = 0; k < C; k++) begin
            pix = m ? int'(c) : (l % 128) * 512 + (k % 512);
            exp_q.push_back(8'(pix >> 8));
            exp_q.push_back(8'(pix & 255));
         end
   endtask

   task automatic start_frame(output int unsigned t0);
      @(posedge clock); #1;
      iniciar = 1'b1;
      t0 = cyc;
      @(posedge clock); #1;
      iniciar = 1'b0;
      chk("ocupado_set", 32'(ocupado), 32'd1);
   endtask

   task automatic wait_fim(input int unsigned lim);
      for (int unsigned i = 0; i < lim && fim_cnt == 0; i++) begin
         @(posedge clock); #2;
      end
      chk("fim_timeout", 32'(fim_cnt != 0), 32'd1);
   endtask

   task automatic check_frame(input string tag, input logic m, input logic [15:0] c,
                              input int unsigned t0);
      int unsigned diff;
      build_exp(m, c);
      repeat (4) @(posedge clock);
      #2;
      chk({tag, "_fim_cnt"}, 32'(fim_cnt), 32'd1);
      chk({tag, "_fim_ocupado"}, 32'(ocup_fim), 32'd0);
      chk({tag, "_vs_rises"}, 32'(vs_rises), 32'd1);
      chk({tag, "_vs_pulses"}, 32'(vlen.size()), 32'd1);
      chk({tag, "_vs_len"}, (vlen.size() > 0) ? 32'(vlen[0]) : 32'd0, 32'(VTP));
      chk({tag, "_href_pulses"}, 32'(hlen.size()), 32'(L));
      foreach (hlen[i]) chk($sformatf("%s_href_len%0d", tag, i), 32'(hlen[i]), 32'(2 * C));
      chk({tag, "_nbytes"}, 32'(cap.size()), 32'(exp_q.size()));
      foreach (exp_q[i])
         chk($sformatf("%s_byte%0d", tag, i), (i < cap.size()) ? 32'(cap[i]) : 32'hdead, 32'(exp_q[i]));
      diff = fim_cyc - vs_cyc;
      chk({tag, "_frame_len"}, 32'(diff + 1 >= FRAME_CLK && diff <= FRAME_CLK + 1), 32'd1);
      chk({tag, "_latency"}, 32'(vs_cyc - t0 <= 2 * PD + 1), 32'd1);
      chk({tag, "_ocupado_end"}, 32'(ocupado), 32'd0);
   endtask

   initial begin
      int unsigned t0, highs;
      logic        m;
      logic [15:0] c;

      // Reset held
      repeat (3) @(posedge clock);
      #2;
      chk("rst_vsync", 32'(VSYNC), 32'd0);
      chk("rst_href", 32'(HREF), 32'd0);
      chk("rst_pclk", 32'(PCLK), 32'd0);
      chk("rst_d", 32'(D), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_fim", 32'(fim_frame), 32'd0);

      // Release: PCLK free-runs with period 2*PD, frame outputs quiet
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      clear_mon();
      highs = 0;
      for (int unsigned i = 0; i < 8 * PD; i++) begin
         @(posedge clock); #2;
         if (PCLK) highs++;
      end
      chk("pclk_rises", 32'(pclk_rises), 32'd4);
      chk("pclk_duty", 32'(highs), 32'(4 * PD));
      chk("idle_vsync", 32'(VSYNC), 32'd0);
      chk("idle_href", 32'(HREF), 32'd0);
      chk("idle_ocupado", 32'(ocupado), 32'd0);

      // Coordinate pattern frame
      clear_mon();
      modo = 1'b0;
      start_frame(t0);
      wait_fim(FRAME_CLK + 50);
      check_frame("coord", 1'b0, 16'h0000, t0);
      chk("l1c2_hi", (cap.size() > 13) ? 32'(cap[12]) : 32'hdead, 32'h02);
      chk("l1c2_lo", (cap.size() > 13) ? 32'(cap[13]) : 32'hdead, 32'h02);
      chk("l2c3_hi", (cap.size() > 23) ? 32'(cap[22]) : 32'hdead, 32'h04);
      chk("l2c3_lo", (cap.size() > 23) ? 32'(cap[23]) : 32'hdead, 32'h03);

      // Constant colour, cor changed mid-frame
      clear_mon();
      modo = 1'b1;
      cor  = 16'hF800;
      start_frame(t0);
      repeat (150) @(posedge clock);
      #1;
      cor = 16'(~16'hF800);
      wait_fim(FRAME_CLK + 50);
      check_frame("red", 1'b1, 16'hF800, t0);

      // Random colour frame
      clear_mon();
      c = 16'($urandom);
      modo = 1'b1;
      cor  = c;
      start_frame(t0);
      cor = 16'($urandom);
      wait_fim(FRAME_CLK + 50);
      check_frame("rndcor", 1'b1, c, t0);

      // iniciar held high across the whole frame and beyond
      clear_mon();
      m = 1'($urandom);
      c = 16'($urandom);
      modo = m;
      cor  = c;
      @(posedge clock); #1;
      iniciar = 1'b1;
      t0 = cyc;
      wait_fim(FRAME_CLK + 50);
      repeat (FRAME_CLK + 40) @(posedge clock);
      check_frame("held", m, c, t0);
      iniciar = 1'b0;
      repeat (3) @(posedge clock);
      clear_mon();
      m = 1'($urandom);
      c = 16'($urandom);
      modo = m;
      cor  = c;
      start_frame(t0);
      wait_fim(FRAME_CLK + 50);
      check_frame("rearm", m, c, t0);

      // Reset during line 1 of the active region
      clear_mon();
      modo = 1'b0;
      start_frame(t0);
      for (int unsigned i = 0; i < FRAME_CLK && !(hlen.size() == 1 && HREF); i++) begin
         @(posedge clock); #2;
      end
      chk("line1_reached", 32'(hlen.size() == 1 && HREF), 32'd1);
      repeat (5) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      chk("mid_rst_vsync", 32'(VSYNC), 32'd0);
      chk("mid_rst_href", 32'(HREF), 32'd0);
      chk("mid_rst_pclk", 32'(PCLK), 32'd0);
      chk("mid_rst_d", 32'(D), 32'd0);
      chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
      clear_mon();
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (FRAME_CLK + 20) @(posedge clock);
      #2;
      chk("mid_rst_no_fim", 32'(fim_cnt), 32'd0);
      chk("mid_rst_no_vs", 32'(vs_rises), 32'd0);
      clear_mon();
      m = 1'($urandom);
      c = 16'($urandom);
      modo = m;
      cor  = c;
      start_frame(t0);
      wait_fim(FRAME_CLK + 50);
      check_frame("restart", m, c, t0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
